scratch_pad_stream_port: RTL

Per-port strided stream engine that sits directly upstream of one `scratch_pad` port. It turns a (base, stride, count) command into a sequence of scratch-pad read or write requests, honouring the port's `full` back-pressure. It caps outstanding reads at the reorder depth. For reads, it collects returned data through a 2-entry buffer and presents it as a valid/ready stream to the consumer.

---
 rtl/scratch_pad_stream_port_pkg.sv | 21 ++
 rtl/scratch_pad_skid.sv | 46 ++++
 rtl/scratch_pad_stream_port.sv | 128 ++++++++++++
 3 files changed

// File: rtl/scratch_pad_stream_port_pkg.sv
// rtl/scratch_pad_stream_port_pkg.sv - shared state encoding and log2 helper for the stream port
package scratch_pad_stream_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/scratch_pad_skid.sv
// rtl/scratch_pad_skid.sv - two-entry return buffer between scratch pad and read stream
module scratch_pad_skid #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       occ;
   logic             push_ok;
   logic             pop_ok;

   assign full      = (occ == 2'd2);
   assign not_empty = (occ != 2'd0);
   assign head      = mem[rd_ptr];
   assign pop_ok    = pop && not_empty;
   // When full, a simultaneous pop frees the slot being overwritten.
   assign push_ok   = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

endmodule

// File: rtl/scratch_pad_stream_port.sv
// rtl/scratch_pad_stream_port.sv - strided read/write stream engine for one scratch-pad port
module scratch_pad_stream_port
   import scratch_pad_stream_port_pkg::*;
#(
   parameter int WIDTH           = 64,
   parameter int ADDR_WIDTH      = 12,
   parameter int COUNT_WIDTH     = 16,
   parameter int MAX_OUTSTANDING = 32,
   parameter int OUT_BITS        = log2(MAX_OUTSTANDING) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   op_write,
   input  logic [ADDR_WIDTH-1:0]  base,
   input  logic [ADDR_WIDTH-1:0]  stride,
   input  logic [COUNT_WIDTH-1:0] count,
   output logic                   busy,
   output logic                   done,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic                   sp_rd_en,
   output logic                   sp_wr_en,
   output logic [ADDR_WIDTH-1:0]  sp_addr,
   output logic [WIDTH-1:0]       sp_d,
   input  logic                   sp_full,
   input  logic [WIDTH-1:0]       sp_q,
   input  logic                   sp_valid,
   output logic                   sp_stall
);

   state_t                 state;
   state_t                 state_nxt;
   logic                   op_r;
   logic [ADDR_WIDTH-1:0]  addr_r;
   logic [ADDR_WIDTH-1:0]  stride_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic [COUNT_WIDTH-1:0] issued;
   logic [OUT_BITS-1:0]    outstanding;

   logic in_issue;
   logic rd_fire;
   logic wr_fire;
   logic fire;
   logic last_fire;
   logic ret_take;

   assign in_issue  = (state == ST_ISSUE);
   assign rd_fire   = in_issue && !op_r && !sp_full &&
                      (outstanding < OUT_BITS'(MAX_OUTSTANDING));
   assign wr_ready  = in_issue && op_r && !sp_full;
   assign wr_fire   = wr_ready && wr_valid;
   assign fire      = rd_fire || wr_fire;
   assign last_fire = fire && (issued == count_r - COUNT_WIDTH'(1));

   // Beats with nothing outstanding (e.g. in IDLE) are accepted and dropped.
   assign ret_take  = sp_valid && !sp_stall && (state != ST_IDLE) &&
                      (outstanding != '0);

   assign sp_rd_en  = rd_fire;
   assign sp_wr_en  = wr_fire;
   assign sp_addr   = addr_r;
   assign sp_d      = (in_issue && op_r) ? wr_data : '0;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   scratch_pad_skid #(.WIDTH(WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push_data (sp_q),
      .push      (ret_take),
      .pop       (rd_ready),
      .head      (rd_data),
      .not_empty (rd_valid),
      .full      (sp_stall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         op_r        <= 1'b0;
         addr_r      <= '0;
         stride_r    <= '0;
         count_r     <= '0;
         issued      <= '0;
         outstanding <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            op_r     <= op_write;
            addr_r   <= base;
            stride_r <= stride;
            count_r  <= count;
            issued   <= '0;
         end else if (fire) begin
            addr_r <= addr_r + stride_r;
            issued <= issued + COUNT_WIDTH'(1);
         end
         case ({rd_fire, ret_take})
            2'b10:   outstanding <= outstanding + OUT_BITS'(1);
            2'b01:   outstanding <= outstanding - OUT_BITS'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (count == '0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (last_fire) state_nxt = op_r ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (outstanding == '0 && !rd_valid) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
